flash_led_ctrl: RTL and testbench

Free-running 4-LED pattern sequencer for board bring-up and heartbeat indication. It divides the system clock into fixed-length steps. On each step it advances through an 8-step frame: a one-hot "running light" followed by two all-LED blinks. The frame then repeats forever. It has no inputs besides clock and reset and sits directly on the board LED pins.

---
 rtl/flash_led_pkg.sv | 23 ++
 rtl/flash_led_ctrl_if.sv | 19 +
 rtl/flash_led_tick.sv | 37 +++
 rtl/flash_led_ctrl.sv | 67 ++++++
 tb/tb_flash_led_ctrl.sv | 114 +++++++++++
 5 files changed

// File: rtl/flash_led_pkg.sv
// flash_led_pkg
//   Shared definitions for the LED pattern sequencer: the phase encoding,
//   the logical (on = 1) pattern for each of the eight frame steps, and the
//   default number of clock cycles per step.
package flash_led_pkg;

    // RUN: steps 0-3 (running light), BLINK: steps 4-7 (all on / all off).
    // The encoding equals step[2], so phase and step can never disagree.
    typedef enum logic {
        RUN   = 1'b0,
        BLINK = 1'b1
    } phase_t;

    // Logical pattern per step, bit 0 = LED0, 1 = lit.
    localparam logic [3:0] LED_PATTERN [0:7] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b1111, 4'b0000, 4'b1111, 4'b0000
    };

    // 0.5 s per step at 100 MHz.
    localparam int STEP_CNT_DEFAULT = 50_000_000;

endpackage

// File: rtl/flash_led_ctrl_if.sv
// flash_led_ctrl_if
//   Output bundle of the LED sequencer.
//   led   : registered physical LED drive (polarity already applied)
//   phase : current phase state (RUN/BLINK), for observation
//   step  : current step index 0..7, for observation
//   master modport drives everything; slave modport observes it.
//   There is no handshake: the outputs are plain registered levels that are
//   valid on every cycle after the first reset edge.
interface flash_led_ctrl_if;
    import flash_led_pkg::*;

    logic [3:0] led;
    phase_t     phase;
    logic [2:0] step;

    modport master (output led, output phase, output step);
    modport slave  (input  led, input  phase, input  step);

endinterface

// File: rtl/flash_led_tick.sv
// flash_led_tick
//   Prescaler: counts 0 .. STEP_CNT-1 and raises tick on the last count.
//   sclk    : system clock, rising edge
//   s_rst_n : synchronous active-low reset (cnt -> 0)
//   tick    : one-cycle step strobe; constant 1 when STEP_CNT == 1
module flash_led_tick #(
    parameter int STEP_CNT = flash_led_pkg::STEP_CNT_DEFAULT
) (
    input  logic sclk,
    input  logic s_rst_n,
    output logic tick
);

    if (STEP_CNT < 1) begin : g_bad_step_cnt
        $error("flash_led_tick: STEP_CNT must be at least 1");
    end

    localparam int CW = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CNT - 1);

    logic [CW-1:0] cnt;

    // The constant term keeps tick at 1 for single-cycle steps even before
    // the counter has ever been reset.
    assign tick = (STEP_CNT == 1) || (cnt == LAST);

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/flash_led_ctrl.sv
// flash_led_ctrl
//   Free-running 4-LED sequencer: an 8-step frame of a one-hot running light
//   (steps 0-3) followed by two all-LED blinks (steps 4-7), one step every
//   STEP_CNT clock cycles, repeating forever.
//   sclk    : system clock, rising edge
//   s_rst_n : synchronous active-low reset (step 0, LED0 lit)
//   led_if  : master side of flash_led_ctrl_if (led, phase, step)
module flash_led_ctrl
    import flash_led_pkg::*;
#(
    parameter int STEP_CNT        = STEP_CNT_DEFAULT,
    parameter bit LED_ACTIVE_HIGH = 1'b1
) (
    input  logic                     sclk,
    input  logic                     s_rst_n,
    flash_led_ctrl_if.master         led_if
);

    // XOR mask turning a logical pattern into the physical pin level.
    localparam logic [3:0] POL_MASK = LED_ACTIVE_HIGH ? 4'b0000 : 4'b1111;

    logic       tick;
    logic [2:0] step_q, step_d;
    phase_t     phase_q, phase_d;
    logic [3:0] led_q, led_d;

    flash_led_tick #(
        .STEP_CNT (STEP_CNT)
    ) u_tick (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .tick    (tick)
    );

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            step_q  <= 3'd0;
            phase_q <= RUN;
            led_q   <= LED_PATTERN[0] ^ POL_MASK;
        end else begin
            step_q  <= step_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    // Step/phase advance on tick; led is loaded with the pattern of the
    // step being entered so it changes on the same edge as the step.
    always_comb begin
        step_d  = step_q;
        phase_d = phase_q;
        if (tick) begin
            step_d = step_q + 3'd1;
            case (phase_q)
                RUN:     if (step_q == 3'd3) phase_d = BLINK;
                BLINK:   if (step_q == 3'd7) phase_d = RUN;
                default: phase_d = RUN;
            endcase
        end
        led_d = LED_PATTERN[step_d] ^ POL_MASK;
    end

    assign led_if.led   = led_q;
    assign led_if.phase = phase_q;
    assign led_if.step  = step_q;

endmodule

// File: tb/tb_flash_led_ctrl.sv
// tb_flash_led_ctrl
//   Four sequencer instances share one clock and reset:
//     dut_a STEP_CNT=4 active-high, dut_b STEP_CNT=1 active-high,
//     dut_c STEP_CNT=4 active-low,  dut_d STEP_CNT=3 active-high.
//   Expected values come from a hand-written pattern table indexed by the
//   number of edges since reset release: step = (k / STEP_CNT) % 8.
module tb_flash_led_ctrl;
    import flash_led_pkg::*;

    // ---------------- clock / reset ----------------
    logic sclk    = 1'b0;
    logic s_rst_n = 1'b0;
    always #5 sclk = ~sclk;

    flash_led_ctrl_if if_a ();
    flash_led_ctrl_if if_b ();
    flash_led_ctrl_if if_c ();
    flash_led_ctrl_if if_d ();

    flash_led_ctrl #(.STEP_CNT(4), .LED_ACTIVE_HIGH(1'b1)) dut_a (
        .sclk(sclk), .s_rst_n(s_rst_n), .led_if(if_a));
    flash_led_ctrl #(.STEP_CNT(1), .LED_ACTIVE_HIGH(1'b1)) dut_b (
        .sclk(sclk), .s_rst_n(s_rst_n), .led_if(if_b));
    flash_led_ctrl #(.STEP_CNT(4), .LED_ACTIVE_HIGH(1'b0)) dut_c (
        .sclk(sclk), .s_rst_n(s_rst_n), .led_if(if_c));
    flash_led_ctrl #(.STEP_CNT(3), .LED_ACTIVE_HIGH(1'b1)) dut_d (
        .sclk(sclk), .s_rst_n(s_rst_n), .led_if(if_d));

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    logic [3:0] pat_tbl [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b1111, 4'b0000, 4'b1111, 4'b0000};

    task automatic check_eq(input string tag, input logic [7:0] act,
                            input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_led(input int k, input int s, input bit ah);
        logic [3:0] p;
        p = pat_tbl[(k / s) % 8];
        return ah ? p : ~p;
    endfunction

    // k = number of rising edges since reset release (0 = reset state).
    task automatic check_all(input int k, input string tag);
        exp_q.push_back({4'b0, exp_led(k, 4, 1'b1)});
        exp_q.push_back({4'b0, exp_led(k, 1, 1'b1)});
        exp_q.push_back({4'b0, exp_led(k, 4, 1'b0)});
        exp_q.push_back({4'b0, exp_led(k, 3, 1'b1)});
        exp_q.push_back({7'b0, (((k / 4) % 8) >= 4) ? 1'b1 : 1'b0});
        exp_q.push_back({5'b0, 3'((k / 3) % 8)});
        check_eq({tag, "_a_led"},   {4'b0, if_a.led},    exp_q.pop_front());
        check_eq({tag, "_b_led"},   {4'b0, if_b.led},    exp_q.pop_front());
        check_eq({tag, "_c_led"},   {4'b0, if_c.led},    exp_q.pop_front());
        check_eq({tag, "_d_led"},   {4'b0, if_d.led},    exp_q.pop_front());
        check_eq({tag, "_a_phase"}, {7'b0, if_a.phase},  exp_q.pop_front());
        check_eq({tag, "_d_step"},  {5'b0, if_d.step},   exp_q.pop_front());
    endtask

    // ---------------- driver ----------------
    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic next_edge();
        @(posedge sclk);
        #1;
    endtask

    task automatic run_checked(input int first_k, input int last_k, input string tag);
        for (int k = first_k; k <= last_k; k++) begin
            next_edge();
            check_all(k, tag);
        end
    endtask

    initial begin
        // Reset held for 100 ns: reset state on every edge.
        for (int i = 0; i < 10; i++) begin
            next_edge();
            check_all(0, "reset");
        end
        s_rst_n = 1'b1;

        // 100 frames of STEP_CNT=3 (2400 cycles); the other instances run
        // whole frames as well over the same span.
        run_checked(1, 2400, "run");

        // Fresh one-cycle reset, then walk dut_a into step 2 (led=0100).
        s_rst_n = 1'b0;
        next_edge();
        check_all(0, "rst_pulse");
        s_rst_n = 1'b1;
        run_checked(1, 9, "pre_mid");
        check_eq("mid_a_is_0100", {4'b0, if_a.led}, 8'b0000_0100);

        // Reset at cycle 2 of that step; dut_b ticks on this edge too, so
        // this also covers reset winning over a tick.
        s_rst_n = 1'b0;
        next_edge();
        check_all(0, "mid_rst");
        s_rst_n = 1'b1;
        run_checked(1, 40, "after_mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
